// File: rtl/mpadder_pkg.sv
// mpadder_pkg
//   Shared sizing helpers for the carry-select multi-precision adder.
//   nblk()      : number of carry-select blocks (floor of WIDTH/BLOCK).
//   top_width() : width of the most significant block. This block absorbs
//                 the remainder, so it is BLOCK..2*BLOCK-1 bits wide.
//   blk_width() : width of block k.
//   LATENCY     : cycles from accept to out_valid.
package mpadder_pkg;

   localparam int LATENCY = 2;

   function automatic int nblk(input int width, input int block);
      return width / block;
   endfunction

   function automatic int top_width(input int width, input int block);
      return width - (width / block - 1) * block;
   endfunction

   function automatic int blk_width(input int width, input int block, input int k);
      return (k == width / block - 1) ? top_width(width, block) : block;
   endfunction

endpackage

// File: rtl/mpadder_csel_pipe_csel_block.sv
// csel_block
//   Speculative block adder for the carry-select scheme. It computes the
//   block sum for both possible carry-ins. The real carry-in selects one
//   of the two results one pipeline stage later.
//   Ports:
//     a, b    in  [W-1:0]  block operands (b already shifted/inverted)
//     sum0    out [W-1:0]  a + b
//     carry0  out          carry-out of a + b
//     sum1    out [W-1:0]  a + b + 1
//     carry1  out          carry-out of a + b + 1
module csel_block #(
   parameter int W = 128
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum0,
   output logic         carry0,
   output logic [W-1:0] sum1,
   output logic         carry1
);

   assign {carry0, sum0} = {1'b0, a} + {1'b0, b};
   assign {carry1, sum1} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/mpadder_csel_pipe.sv
// mpadder_csel_pipe
//   Two-stage pipelined carry-select adder/subtractor for the Montgomery
//   datapath.
//   Stage 1 registers the per-block speculative sums and carries.
//   Stage 2 resolves the block carry chain, selects the block sums and
//   registers the result.
//
//   Handshake: a transfer happens on a rising edge when valid && ready.
//   The producer holds its data stable until that edge. in_ready is
//   combinational: it is low only while a result is waiting and
//   out_ready is low. In that case every stage holds its contents.
//
//   Ports:
//     clk        in             rising-edge clock
//     rst        in             asynchronous active-high reset
//     in_valid   in             operands/mode valid
//     in_ready   out            block can accept this cycle
//     in_a       in  [WIDTH-1:0] operand A
//     in_b       in  [WIDTH-1:0] operand B
//     leftshift  in             use B' = {in_b[WIDTH-2:0],1'b0}
//     subtract   in             compute A + ~B' + 1
//     cin        in             (only with MPADDER_CIN_EN) carry-in in add mode
//     out_valid  out            result valid
//     out_ready  in             downstream accepts result
//     result     out [WIDTH:0]  sum; bit WIDTH is the carry-out. In subtract
//                               mode this bit is 1 when there is no borrow.
//
//   Optional feature macro: MPADDER_CIN_EN. It adds the cin port.
//   Subtract mode ignores cin.
module mpadder_csel_pipe
   import mpadder_pkg::*;
#(
   parameter int WIDTH = 1027,
   parameter int BLOCK = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             leftshift,
   input  logic             subtract,
`ifdef MPADDER_CIN_EN
   input  logic             cin,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result
);

   localparam int NBLK = nblk(WIDTH, BLOCK);
   localparam int B0W  = blk_width(WIDTH, BLOCK, 0);

   logic             stall;
   logic             accept;
   logic [WIDTH-1:0] b_shift;
   logic [WIDTH-1:0] b_eff;
   logic             cin0;
   logic [B0W:0]     lo_d;

   // Stage 1 state for block 0. Its carry-in is known at accept time, so
   // only one sum is kept.
   logic             v1;
   logic [B0W-1:0]   s1_sum_lo;
   logic             s1_c_lo;

   // Stage 2 input: the fully resolved sum. Different generate blocks
   // drive it slice by slice.
   wire  [WIDTH:0]   res_d;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   // Operand preparation. The MSB of B is dropped on a shift. The width
   // does not grow.
   assign b_shift = leftshift ? {in_b[WIDTH-2:0], 1'b0} : in_b;
   assign b_eff   = subtract ? ~b_shift : b_shift;

`ifdef MPADDER_CIN_EN
   assign cin0 = subtract | cin;
`else
   assign cin0 = subtract;
`endif

   assign lo_d = {1'b0, in_a[B0W-1:0]} + {1'b0, b_eff[B0W-1:0]} + {{B0W{1'b0}}, cin0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         s1_sum_lo <= '0;
         s1_c_lo   <= 1'b0;
      end else if (!stall) begin
         v1 <= in_valid;
         if (accept) begin
            s1_sum_lo <= lo_d[B0W-1:0];
            s1_c_lo   <= lo_d[B0W];
         end
      end
   end

   generate
      if (NBLK == 1) begin : g_single
         // A single block already holds the resolved sum.
         assign res_d = {s1_c_lo, s1_sum_lo};
      end else begin : g_multi
         wire  [WIDTH-1:B0W] sum0_d;
         wire  [WIDTH-1:B0W] sum1_d;
         wire  [NBLK-1:1]    c0_d;
         wire  [NBLK-1:1]    c1_d;
         logic [WIDTH-1:B0W] s1_sum0;
         logic [WIDTH-1:B0W] s1_sum1;
         logic [NBLK-1:1]    s1_c0;
         logic [NBLK-1:1]    s1_c1;
         // chain[k] is the resolved carry into block k. chain[NBLK] is the
         // final carry-out.
         wire  [NBLK:1]      chain;

         assign chain[1]          = s1_c_lo;
         assign res_d[B0W-1:0]    = s1_sum_lo;
         assign res_d[WIDTH]      = chain[NBLK];

         for (genvar k = 1; k < NBLK; k++) begin : g_blk
            localparam int BW = blk_width(WIDTH, BLOCK, k);
            localparam int LO = k * BLOCK;

            csel_block #(
               .W(BW)
            ) u_blk (
               .a      (in_a[LO +: BW]),
               .b      (b_eff[LO +: BW]),
               .sum0   (sum0_d[LO +: BW]),
               .carry0 (c0_d[k]),
               .sum1   (sum1_d[LO +: BW]),
               .carry1 (c1_d[k])
            );

            // Only a mux delay per block sits on the stage 2 carry path.
            assign chain[k+1]       = chain[k] ? s1_c1[k] : s1_c0[k];
            assign res_d[LO +: BW]  = chain[k] ? s1_sum1[LO +: BW] : s1_sum0[LO +: BW];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_sum0 <= '0;
               s1_sum1 <= '0;
               s1_c0   <= '0;
               s1_c1   <= '0;
            end else if (accept) begin
               s1_sum0 <= sum0_d;
               s1_sum1 <= sum1_d;
               s1_c0   <= c0_d;
               s1_c1   <= c1_d;
            end
         end
      end
   endgenerate

   // Output stage. When a stage-1 bubble moves forward, the old result
   // value stays in place and out_valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
      end else if (!stall) begin
         out_valid <= v1;
         if (v1) begin
            result <= res_d;
         end
      end
   end

endmodule

// File: tb/tb_mpadder_csel_pipe.sv
// tb_mpadder_csel_pipe
//   Directed bench for mpadder_csel_pipe with the default 1027-bit / 128-bit
//   block configuration. It drives inputs on the falling edge and samples
//   outputs on the falling edge.
module tb_mpadder_csel_pipe;

   localparam int W = 1027;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         leftshift;
   logic         subtract;
`ifdef MPADDER_CIN_EN
   logic         cin;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   result;

   int           checks   = 0;
   int           failures = 0;
   logic [W:0]   exp_q[$];

   logic [W-1:0] bp_a [4];
   logic [W-1:0] bp_b [4];
   int           sent;
   int           got;
   int           first_ov;
   int           stall_cnt;

   always #5 clk = ~clk;

   mpadder_csel_pipe #(
      .WIDTH (W),
      .BLOCK (128)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .leftshift (leftshift),
      .subtract  (subtract),
`ifdef MPADDER_CIN_EN
      .cin       (cin),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed_hi=%h observed_lo=%h expected_hi=%h expected_lo=%h",
                tag, obs[W:W-63], obs[127:0], exp[W:W-63], exp[127:0]);
      end
   endtask

   // Sends one operation with an empty pipeline. Checks the 2-cycle
   // latency and the result. After the accept, the inputs are scrambled.
   task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ls, input logic sub, input logic [W:0] exp);
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      leftshift = ls;
      subtract  = sub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      in_a      = ~a;
      in_b      = ~b;
      leftshift = ~ls;
      subtract  = ~sub;
      chk({tag, "_lat1_out_valid"}, out_valid, 0);
      @(negedge clk);
      chk({tag, "_lat2_out_valid"}, out_valid, 1);
      chk({tag, "_result"}, result, exp);
   endtask

   initial begin
      // Reset
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      leftshift = 1'b0;
      subtract  = 1'b0;
      out_ready = 1'b1;
`ifdef MPADDER_CIN_EN
      cin       = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // Directed arithmetic
      // (2^1027-1) + 1 = 2^1027: only the carry-out bit is set
      single_op("add_wrap", {W{1'b1}}, W'(1), 1'b0, 1'b0, {1'b1, {W{1'b0}}});
      // (2^1026-1) + 1 = 2^1026: the carry ripples through every block
      single_op("add_ripple", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0,
                {2'b01, {(W-1){1'b0}}});
      // 0 + ((2^1026+3) << 1) with the MSB dropped = 6
      single_op("leftshift", '0, {1'b1, {(W-3){1'b0}}, 2'b11}, 1'b1, 1'b0, (W+1)'(6));
      // 5 - 7 = -2 mod 2^1027, borrow (carry-out 0)
      single_op("sub_neg", W'(5), W'(7), 1'b0, 1'b1, {1'b0, {(W-1){1'b1}}, 1'b0});
      // 7 - 5 = 2, no borrow (carry-out 1)
      single_op("sub_pos", W'(7), W'(5), 1'b0, 1'b1, {1'b1, {(W-2){1'b0}}, 2'b10});
      // 10 - (3 << 1) = 4, no borrow
      single_op("sub_shift", W'(10), W'(3), 1'b1, 1'b1, {1'b1, {(W-3){1'b0}}, 3'b100});
      // (2^128-1) + 1 = 2^128: carry from block 0 into block 1
      single_op("blk0_edge", {{(W-128){1'b0}}, {128{1'b1}}}, W'(1), 1'b0, 1'b0,
                {{(W-128){1'b0}}, 1'b1, {128{1'b0}}});
      // (2^896-1) + 1 = 2^896: carry into the wide top block
      single_op("top_edge", {{(W-896){1'b0}}, {896{1'b1}}}, W'(1), 1'b0, 1'b0,
                {{(W-896){1'b0}}, 1'b1, {896{1'b0}}});
      // all-ones + all-ones = 2^1028 - 2
      single_op("add_max", {W{1'b1}}, {W{1'b1}}, 1'b0, 1'b0, {{W{1'b1}}, 1'b0});

      // Backpressure: four ops offered back to back, out_ready low for
      // three cycles starting at the first out_valid
      bp_a[0] = W'(1); bp_b[0] = W'(2);
      bp_a[1] = W'(3); bp_b[1] = W'(4);
      bp_a[2] = W'(5); bp_b[2] = W'(6);
      bp_a[3] = W'(7); bp_b[3] = W'(8);
      exp_q.push_back((W+1)'(3));
      exp_q.push_back((W+1)'(7));
      exp_q.push_back((W+1)'(11));
      exp_q.push_back((W+1)'(15));
      leftshift = 1'b0;
      subtract  = 1'b0;
      sent      = 0;
      got       = 0;
      first_ov  = -1;
      stall_cnt = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         if (out_valid && first_ov < 0) first_ov = cyc;
         out_ready = !(first_ov >= 0 && cyc < first_ov + 3);
         in_valid  = (sent < 4);
         if (sent < 4) begin
            in_a = bp_a[sent];
            in_b = bp_b[sent];
         end
         #1;
         if (out_valid && !out_ready) begin
            stall_cnt++;
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_result_held", result, exp_q[0]);
         end
         if (out_valid && out_ready) begin
            chk("bp_data", result, exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_sent", sent, 4);
      chk("bp_got", got, 4);
      chk("bp_stall_cycles", stall_cnt, 3);
      @(negedge clk);
      chk("bp_no_duplicate", out_valid, 0);

      // Reset while two ops are in flight
      @(negedge clk);
      in_a     = W'(100);
      in_b     = W'(200);
      in_valid = 1'b1;
      @(negedge clk);
      in_a     = W'(300);
      in_b     = W'(400);
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_out_valid", out_valid, 1);
      chk("mid_result", result, (W+1)'(300));
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_no_ghost", out_valid, 0);
      single_op("post_rst", W'(123), W'(456), 1'b0, 1'b0, (W+1)'(579));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
